// File: rtl/req_ack_pkg.sv
// rtl/req_ack_pkg.sv - shared types and defaults for the req/ack issuer and responder
package req_ack_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } issuer_state_t;

    localparam int DEF_MIN_GAP = 8;
    localparam int DEF_ACK_LAT = 4;
    localparam int DEF_CNT_W   = 32;

endpackage

// File: rtl/req_delay_line.sv
// rtl/req_delay_line.sv - DEPTH-stage synchronous-reset shift register for a single bit
module req_delay_line #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/req_pulse_issuer.sv
// rtl/req_pulse_issuer.sv - start-driven req pulse issuer with ack counting
// Optional ack latency checker: REQ_PULSE_ISSUER_ACK_CHECK_EN
module req_pulse_issuer
    import req_ack_pkg::*;
#(
    parameter int MIN_GAP = DEF_MIN_GAP,
    parameter int ACK_LAT = DEF_ACK_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    output logic             req,
    input  logic             ack,
    output logic             busy,
    output logic [CNT_W-1:0] reqs_issued,
    output logic [CNT_W-1:0] acks_seen,
    output logic             ack_err
);

    localparam int GW = $clog2(MIN_GAP);

    issuer_state_t state;
    logic [GW-1:0] gap_cnt;
    logic          ack_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req         <= 1'b0;
            start_ready <= 1'b1;
            gap_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        state       <= PULSE;
                        req         <= 1'b1;
                        start_ready <= 1'b0;
                    end
                end
                PULSE: begin
                    req <= 1'b0;
                    if (MIN_GAP == 2) begin
                        state       <= IDLE;
                        start_ready <= 1'b1;
                    end else begin
                        state   <= GAP;
                        gap_cnt <= GW'(MIN_GAP - 2);
                    end
                end
                GAP: begin
                    req     <= 1'b0;
                    gap_cnt <= gap_cnt - GW'(1);
                    if (gap_cnt == GW'(1)) begin
                        state       <= IDLE;
                        start_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req         <= 1'b0;
                    start_ready <= 1'b1;
                end
            endcase
        end
    end

    // ack is counted on its rising edge so a stretched ack counts once
    always_ff @(posedge clk) begin
        if (rst) begin
            reqs_issued <= '0;
            acks_seen   <= '0;
            ack_q       <= 1'b0;
        end else begin
            ack_q <= ack;
            if (req) begin
                reqs_issued <= reqs_issued + CNT_W'(1);
            end
            if (ack && !ack_q) begin
                acks_seen <= acks_seen + CNT_W'(1);
            end
        end
    end

    assign busy = (state != IDLE) || (reqs_issued != acks_seen);

`ifdef REQ_PULSE_ISSUER_ACK_CHECK_EN
    localparam int QW = $clog2(ACK_LAT + 1);

    logic          exp_ack;
    logic [QW-1:0] quiet;

    req_delay_line #(
        .DEPTH(ACK_LAT)
    ) u_delay (
        .clk(clk),
        .rst(rst),
        .d  (req),
        .q  (exp_ack)
    );

    // After reset, acks for pulses issued before reset may still arrive for
    // ACK_LAT cycles; they are counted but must not raise an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_err <= 1'b0;
            quiet   <= QW'(ACK_LAT);
        end else begin
            if (quiet != '0) begin
                quiet <= quiet - QW'(1);
            end
            if (quiet == '0 && ack != exp_ack) begin
                ack_err <= 1'b1;
            end
        end
    end

`ifdef FORMAL
    a_min_gap: assert property (@(posedge clk) disable iff (rst)
        req |-> ##1 !req [* MIN_GAP-1]);
`endif
`else
    assign ack_err = 1'b0;
`endif

endmodule

// File: tb/tb_req_pulse_issuer.sv
// tb/tb_req_pulse_issuer.sv - self-checking bench for req_pulse_issuer
module tb_req_pulse_issuer;
    import req_ack_pkg::*;

    localparam int MG = DEF_MIN_GAP;
    localparam int AL = DEF_ACK_LAT;
`ifdef REQ_PULSE_ISSUER_ACK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_valid = 1'b0;
    logic ack = 1'b0;

    logic        rdy, req, busy, err;
    logic [31:0] ri, as;
    logic        rdy_w, req_w, busy_w, err_w;
    logic [2:0]  ri_w, as_w;

    always #5 clk = ~clk;

    req_pulse_issuer dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(rdy),
        .req(req), .ack(ack), .busy(busy), .reqs_issued(ri), .acks_seen(as),
        .ack_err(err)
    );

    req_pulse_issuer #(.MIN_GAP(MG), .ACK_LAT(AL), .CNT_W(3)) dut_w (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(rdy_w),
        .req(req_w), .ack(ack), .busy(busy_w), .reqs_issued(ri_w), .acks_seen(as_w),
        .ack_err(err_w)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int base = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc - base, act, exp);
        end
    endtask

    // Behavioural model: timestamps of the next pulse and of the next idle cycle
    int m_idle_at = 0, m_req_at = -100, m_issued = 0, m_acks = 0, m_rst_cyc = 0;
    bit m_ack_q = 1'b0, m_err = 1'b0, m_live = 1'b0, exp_now;
    int exp_q[$];

    initial forever @(posedge clk) begin
        if (rst) begin
            m_idle_at = cyc + 1;
            m_req_at  = -100;
            m_issued  = 0;
            m_acks    = 0;
            m_ack_q   = 1'b0;
            m_err     = 1'b0;
            exp_q.delete();
            m_rst_cyc = cyc;
            m_live    = 1'b1;
        end else begin
            if (cyc == m_req_at) begin
                m_issued++;
                exp_q.push_back(cyc + AL);
            end
            if (cyc >= m_idle_at && start_valid) begin
                m_req_at  = cyc + 1;
                m_idle_at = cyc + MG;
            end
            if (ack && !m_ack_q) m_acks++;
            m_ack_q = ack;
            exp_now = (exp_q.size() > 0 && exp_q[0] == cyc);
            if (exp_now) void'(exp_q.pop_front());
            if (CHK && cyc > m_rst_cyc + AL && ack != exp_now) m_err = 1'b1;
        end
        cyc++;
    end

    // Compare process and pulse log
    int plog[$];
    initial forever @(negedge clk) begin
        if (m_live) begin
            bit e_rdy;
            e_rdy = (cyc >= m_idle_at);
            chk("req", req, 32'(cyc == m_req_at));
            chk("start_ready", rdy, 32'(e_rdy));
            chk("busy", busy, 32'(!e_rdy || m_issued != m_acks));
            chk("reqs_issued", ri, 32'(m_issued));
            chk("acks_seen", as, 32'(m_acks));
            chk("ack_err", err, 32'(m_err));
            chk("w_req", req_w, 32'(cyc == m_req_at));
            chk("w_busy", busy_w, 32'(!e_rdy || (m_issued % 8) != (m_acks % 8)));
            chk("w_reqs_issued", ri_w, 32'(m_issued % 8));
            chk("w_acks_seen", as_w, 32'(m_acks % 8));
            if (req === 1'b1) plog.push_back(cyc - base);
        end
    end

    // Responder: echoes req after resp_lat cycles
    bit resp_en = 1'b0;
    int resp_lat = AL;
    bit reqh [0:8191];
    initial forever @(negedge clk) begin
        reqh[cyc] = (req === 1'b1);
        ack = resp_en && cyc >= resp_lat && reqh[cyc - resp_lat];
    end

    task automatic do_reset();
        rst = 1'b1;
        start_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        base = cyc;
    endtask

    task automatic goto(input int rel);
        while (cyc - base < rel) @(negedge clk);
    endtask

    initial begin
        resp_en = 1'b1;

        // Reset then idle
        do_reset();
        for (int i = 0; i < 20; i++) begin
            goto(i);
            chk("idle_req", req, 0);
            if (i >= 1) chk("idle_ready", rdy, 1);
        end
        chk("idle_busy", busy, 0);
        chk("idle_cnt", ri | as, 0);

        // Single start at cycle 5
        do_reset();
        goto(5); start_valid = 1'b1;
        goto(6); start_valid = 1'b0;
        chk("single_req6", req, 1);
        for (int i = 6; i <= 12; i++) begin
            goto(i);
            chk("single_notready", rdy, 0);
        end
        goto(7);  chk("single_issued7", ri, 1);
        goto(11); chk("single_acks11", as, 1);
        goto(13); chk("single_ready13", rdy, 1); chk("single_busy13", busy, 0);
        chk("single_err", err, 0);

        // Held start_valid for 40 cycles
        do_reset();
        plog.delete();
        start_valid = 1'b1;
        goto(40); start_valid = 1'b0;
        goto(45);
        chk("held_npulses", plog.size(), 5);
        for (int i = 0; i < 5 && i < plog.size(); i++) chk("held_pulse_at", plog[i], 1 + 8 * i);
        chk("held_issued", ri, 5);
        chk("held_acks", as, 5);
        chk("held_err", err, 0);

        // Acks one cycle late
        do_reset();
        resp_lat = AL + 1;
        goto(5); start_valid = 1'b1;
        goto(6); start_valid = 1'b0;
        goto(10); chk("late_err10", err, 0);
        goto(11); chk("late_err11", err, 32'(CHK));
        goto(20); chk("late_err_sticky", err, 32'(CHK));
        resp_lat = AL;
        do_reset();
        chk("late_err_cleared", err, 0);

        // Reset during GAP, then restart
        do_reset();
        goto(5); start_valid = 1'b1;
        goto(6); start_valid = 1'b0;
        goto(9); rst = 1'b1;
        goto(10); rst = 1'b0;
        chk("gaprst_ready", rdy, 1);
        chk("gaprst_issued", ri, 0);
        chk("gaprst_acks", as, 0);
        start_valid = 1'b1;
        goto(11); start_valid = 1'b0;
        chk("gaprst_req11", req, 1);
        chk("gaprst_lateack", as, 1);
        goto(17); chk("gaprst_err", err, 0);

        // Counter wrap on the 3-bit instance
        do_reset();
        start_valid = 1'b1;
        goto(72); start_valid = 1'b0;
        goto(80);
        chk("wrap_issued_w", ri_w, 1);
        chk("wrap_acks_w", as_w, 1);
        chk("wrap_busy_w", busy_w, 0);
        chk("wrap_issued", ri, 9);
        chk("wrap_acks", as, 9);
        chk("wrap_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
